// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Producer side of the register file write port. Each cycle at most one result
// is selected and registered onto rd/data/should_write. Load completions from
// the memory unit always win; ALU results either bypass straight through or
// wait in a small in-order FIFO while loads own the port. Returning load words
// are byte/half extracted and sign/zero extended RISC-V style. A pending-load
// scoreboard lets the issue stage stall on read-after-load hazards.
//
// Ports:
//   clock          rising-edge system clock
//   reset_n        asynchronous active-low reset
//   alu_valid      ALU result offered
//   alu_ready      ALU result accepted when alu_valid & alu_ready
//   alu_rd         ALU destination register
//   alu_data       ALU result value
//   load_issue     a load was issued this cycle
//   load_issue_rd  destination of the issued load
//   mem_valid      load data returning (never back-pressured)
//   mem_rd         destination of the returning load
//   mem_funct3     load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   mem_offset     byte offset of the load address within the word
//   mem_data       raw aligned word from memory
//   query_rs1      issue-stage source register 1
//   query_rs2      issue-stage source register 2
//   hazard         either query register has a load outstanding
//   rd             register file write index (registered)
//   data           register file write data (registered)
//   should_write   register file write enable (registered)
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int REG_COUNT      = 32,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [$clog2(REG_COUNT)-1:0] alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         load_issue,
  input  logic [$clog2(REG_COUNT)-1:0] load_issue_rd,
  input  logic                         mem_valid,
  input  logic [$clog2(REG_COUNT)-1:0] mem_rd,
  input  logic [2:0]                   mem_funct3,
  input  logic [1:0]                   mem_offset,
  input  logic [XLEN-1:0]              mem_data,
  input  logic [$clog2(REG_COUNT)-1:0] query_rs1,
  input  logic [$clog2(REG_COUNT)-1:0] query_rs2,
  output logic                         hazard,
  output logic [$clog2(REG_COUNT)-1:0] rd,
  output logic [XLEN-1:0]              data,
  output logic                         should_write
);

  localparam int RW = $clog2(REG_COUNT);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  // ---------------------------------------------------------------------------
  // Load data extraction and extension
  // ---------------------------------------------------------------------------

  // Halfword selection only looks at off[1]; misaligned halves are not split
  // across the word, the low offset bit is simply ignored.
  function automatic logic [XLEN-1:0] extend_load(
    input logic [2:0]      funct3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [XLEN-1:0] result;
    unique case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      3'b000:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  result = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

  logic [XLEN-1:0] load_value;

  assign load_value = extend_load(mem_funct3, mem_offset, mem_data);

  // ---------------------------------------------------------------------------
  // ALU result FIFO state
  // ---------------------------------------------------------------------------

  logic [RW-1:0]   fifo_rd   [ALU_FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [ALU_FIFO_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;

  logic            fifo_empty;
  logic            alu_accept;
  logic            push;
  logic            pop;

  // Depth is a power of two, so the count MSB is set exactly when full. Only
  // the registered count feeds this so alu_ready has no path from mem_valid.
  assign alu_ready  = ~count[PW];
  assign fifo_empty = (count == '0);
  assign alu_accept = alu_valid & alu_ready;

  // ---------------------------------------------------------------------------
  // Write-port arbitration
  // ---------------------------------------------------------------------------

  logic            sel_valid;
  logic [RW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  // Loads first, then the oldest buffered ALU result, then a direct bypass.
  // An accepted ALU result that cannot go out this cycle is queued behind any
  // older entries so ALU program order is preserved.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = alu_rd;
    sel_data  = alu_data;
    pop       = 1'b0;
    if (mem_valid) begin
      sel_valid = 1'b1;
      sel_rd    = mem_rd;
      sel_data  = load_value;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[head];
      sel_data  = fifo_data[head];
      pop       = 1'b1;
    end else if (alu_accept) begin
      sel_valid = 1'b1;
    end
    push = alu_accept & (mem_valid | ~fifo_empty);
  end

  // ---------------------------------------------------------------------------
  // Pending-load scoreboard
  // ---------------------------------------------------------------------------

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_set;
  logic [REG_COUNT-1:0] busy_clr;

  // x0 is never marked, so bit 0 stays clear and queries of x0 never stall.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (load_issue && (load_issue_rd != '0)) begin
      busy_set[load_issue_rd] = 1'b1;
    end
    if (mem_valid) begin
      busy_clr[mem_rd] = 1'b1;
    end
  end

  assign hazard = busy[query_rs1] | busy[query_rs2];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // FIFO storage carries no reset; head/tail/count decide what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[tail]   <= alu_rd;
      fifo_data[tail] <= alu_data;
    end
  end

  // Output register, FIFO pointers and scoreboard. On an idle cycle rd/data
  // keep their old values and only the enable drops. Applying the set after
  // the clear lets a newly issued load keep its bit even when an older load
  // to the same register returns in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd           <= '0;
      data         <= '0;
      should_write <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
    end else begin
      should_write <= sel_valid & (sel_rd != '0);
      if (sel_valid) begin
        rd   <= sel_rd;
        data <= sel_data;
      end

      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register file write port: drives rd, data and should_write into the registers block.
- Merges single-cycle ALU results with out-of-order load completions from the memory unit.
- Applies RISC-V load sign/zero extension.
- Keeps a pending-load scoreboard that the issue stage queries to stall on read-after-load hazards.

Parameters:
- XLEN, 32, data width
- REG_COUNT, 32, architectural registers (index width 5)
- ALU_FIFO_DEPTH, 2, ALU results buffered while loads win arbitration (power of 2, >=2)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- load_issue  in  1  load issued this cycle
- load_issue_rd  in  5  destination of issued load
- mem_valid  in  1  load data returning (always accepted)
- mem_rd  in  5  destination of returning load
- mem_funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- mem_offset  in  2  byte offset of address
- mem_data  in  XLEN  raw aligned word from memory
- query_rs1  in  5  issue-stage source 1
- query_rs2  in  5  issue-stage source 2
- hazard  out  1  combinational: either query register has a pending load
- rd  out  5  register file write index
- data  out  XLEN  register file write data
- should_write  out  1  register file write enable

Behaviour:
- Reset (async, reset_n=0):
  - rd=0, data=0, should_write=0
  - FIFO empty, scoreboard all clear
  - alu_ready=1 once reset_n is 1
- Outputs rd/data/should_write are registered. A value selected in cycle N is presented during N+1, so the register file writes it on edge N+2.
- Arbitration per cycle, priority order:
  1. mem_valid: load result.
  2. Otherwise FIFO head (pop).
  3. Otherwise direct alu_valid&alu_ready (FIFO bypass, only when FIFO empty).
  4. Otherwise should_write=0; rd and data hold their last values.
- ALU results:
  - Enter the FIFO when mem_valid=1 or the FIFO is non-empty, preserving ALU order.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- alu_ready = (count < ALU_FIFO_DEPTH), computed from the registered count only.
- Load extension:
  - lb/lbu select byte mem_data[8*off+7 : 8*off].
  - lh/lhu select half mem_data[16*off[1]+15 : 16*off[1]]; off[0] is ignored.
  - lw takes the full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Unlisted funct3 values are treated as lw.
- x0 rule: any selected result with rd=0 yields should_write=0 (rd and data still update). It consumes its slot normally.
- Scoreboard (REG_COUNT bits):
  - load_issue sets bit load_issue_rd, except for rd 0.
  - mem_valid clears bit mem_rd.
  - Same-cycle set and clear of the same index: set wins, because the new load is younger.
- hazard = busy[query_rs1] | busy[query_rs2]. Index 0 never reports a hazard.
- Overflow: alu_valid while alu_ready=0 is not accepted and not recorded; the producer must hold its values.
- mem_valid with an already-clear scoreboard bit is still written back; no error is flagged.
- Reset mid-operation: FIFO contents and pending bits are discarded, and should_write drops to 0 immediately (asynchronous).

Test Plan:
- Reset, then alu_valid, rd=10, data=999 for one cycle → next cycle rd=10, data=999, should_write=1; registers block reads x10=999 afterwards.
- alu rd=5 data=7 and mem_valid rd=6 funct3=010 data=0x12345678 in the same cycle:
  - Cycle+1: rd=6, data=0x12345678.
  - Cycle+2: rd=5, data=7.
  - alu_ready stays 1.
- mem_valid held 3 cycles while ALU pushes 3 results → alu_ready=0 after 2 pushes; the third is accepted only after a pop; drain order matches push order.
- Load extension with mem_data=0x80F0_7F81:
  - lb off=0 → 0xFFFFFF81
  - lbu off=0 → 0x00000081
  - lb off=1 → 0x0000007F
  - lh off=2 → 0xFFFF80F0
  - lhu off=2 → 0x000080F0
- load_issue rd=3, query_rs1=3 → hazard=1 the next cycle.
  - mem_valid rd=3 with simultaneous load_issue rd=3 → hazard stays 1.
  - A later mem_valid rd=3 → hazard=0.
  - load_issue rd=0 → hazard never set.
- alu rd=0 data=55 → should_write=0. Assert reset_n=0 with 2 FIFO entries pending → should_write=0 immediately, alu_ready=1 after release, no stale writes.
